// File: rtl/pipelined_mem_server_pkg.sv
// Shared memory-message types for MemIntf clients and servers.
// Optional load port macro: PIPELINED_MEM_SERVER_LOAD_PORT_EN.
package pipelined_mem_server_pkg;

  typedef enum logic {
    MEM_MSG_READ  = 1'b0,
    MEM_MSG_WRITE = 1'b1
  } mem_op_t;

  typedef struct packed {
    mem_op_t     op;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } mem_msg_t;

  function automatic logic [31:0] mem_strb_mask(input logic [3:0] strb);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{strb[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/mem_resp_queue.sv
// FIFO of mem_msg_t responses; zero-latency head, no enqueue-to-dequeue bypass.
// Enqueue is never refused; the owner guarantees space via credits.
module mem_resp_queue
  import pipelined_mem_server_pkg::*;
#(
  parameter int p_depth = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     enq_val,
  input  mem_msg_t enq_msg,
  input  logic     deq_rdy,
  output logic     deq_val,
  output mem_msg_t deq_msg,
  output logic     full,
  output logic     empty
);

  localparam int PW = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int CW = $clog2(p_depth + 1);

  mem_msg_t        slots [p_depth];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            deq_xfer;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(p_depth - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CW'(p_depth));
  assign deq_val  = !empty;
  assign deq_msg  = slots[rd_ptr];
  assign deq_xfer = deq_val && deq_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq_val)  wr_ptr <= next_ptr(wr_ptr);
      if (deq_xfer) rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(enq_val) - CW'(deq_xfer);
    end
  end

  // When full with a simultaneous dequeue, wr_ptr == rd_ptr and the head is read before overwrite.
  always_ff @(posedge clk) begin
    if (enq_val) slots[wr_ptr] <= enq_msg;
  end

endmodule

// File: rtl/pipelined_mem_server.sv
// MemIntf server: word-addressed array, fixed p_latency responses in order, credit-limited queue.
// Optional preload port under `ifdef PIPELINED_MEM_SERVER_LOAD_PORT_EN.
module pipelined_mem_server
  import pipelined_mem_server_pkg::*;
#(
  parameter int p_num_words  = 256,
  parameter int p_latency    = 2,
  parameter int p_resp_depth = 4
) (
  input  logic        clk,
  input  logic        rst,
`ifdef PIPELINED_MEM_SERVER_LOAD_PORT_EN
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
`endif
  input  logic        req_val,
  output logic        req_rdy,
  input  mem_msg_t    req_msg,
  output logic        resp_val,
  input  logic        resp_rdy,
  output mem_msg_t    resp_msg
);

  localparam int IW = $clog2(p_num_words);
  localparam int CW = $clog2(p_resp_depth + 1);

  logic [31:0]   mem [p_num_words];
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic          req_xfer;
  logic          resp_xfer;
  mem_msg_t      s0_msg;
  logic          enq_val;
  mem_msg_t      enq_msg;
  logic          q_full;
  logic          q_empty;

  assign idx       = req_msg.addr[2 +: IW];
  assign req_rdy   = (cnt < CW'(p_resp_depth));
  assign req_xfer  = req_val && req_rdy;
  assign resp_xfer = resp_val && resp_rdy;

  always_comb begin
    s0_msg      = req_msg;
    s0_msg.data = (req_msg.op == MEM_MSG_READ) ? mem[idx] : '0;
  end

  // Array is deliberately not reset; a later load overrides a same-word request write.
  always_ff @(posedge clk) begin
    if (req_xfer && !rst && req_msg.op == MEM_MSG_WRITE) begin
      mem[idx] <= (mem[idx] & ~mem_strb_mask(req_msg.strb))
                | (req_msg.data & mem_strb_mask(req_msg.strb));
    end
`ifdef PIPELINED_MEM_SERVER_LOAD_PORT_EN
    if (load_en) mem[load_addr[2 +: IW]] <= load_data;
`endif
  end

`ifdef PIPELINED_MEM_SERVER_LOAD_PORT_EN
  logic unused_load_bits;
  assign unused_load_bits = ^{load_addr[1:0], load_addr[31:IW+2]};
`endif

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt + CW'(req_xfer) - CW'(resp_xfer);
  end

  // The queue register supplies the last cycle of latency, so only p_latency-1 stages live here.
  if (p_latency == 1) begin : g_direct
    assign enq_val = req_xfer;
    assign enq_msg = s0_msg;
  end else begin : g_pipe
    logic     pv [p_latency-1];
    mem_msg_t pm [p_latency-1];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < p_latency - 1; k++) pv[k] <= 1'b0;
      end else begin
        pv[0] <= req_xfer;
        for (int k = 1; k < p_latency - 1; k++) pv[k] <= pv[k-1];
      end
      pm[0] <= s0_msg;
      for (int k = 1; k < p_latency - 1; k++) pm[k] <= pm[k-1];
    end

    assign enq_val = pv[p_latency-2];
    assign enq_msg = pm[p_latency-2];
  end

  mem_resp_queue #(.p_depth(p_resp_depth)) u_resp_queue (
    .clk     (clk),
    .rst     (rst),
    .enq_val (enq_val),
    .enq_msg (enq_msg),
    .deq_rdy (resp_rdy),
    .deq_val (resp_val),
    .deq_msg (resp_msg),
    .full    (q_full),
    .empty   (q_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(enq_val && q_full && !resp_xfer));
      assert (cnt != '0 || q_empty);
    end
  end

endmodule

// File: tb/tb_pipelined_mem_server.sv
// Directed bench for pipelined_mem_server (latency 2, depth 4, 256 words).
// Covers load-port priority when PIPELINED_MEM_SERVER_LOAD_PORT_EN is defined.
module tb_pipelined_mem_server;
  import pipelined_mem_server_pkg::*;

  logic     clk      = 1'b0;
  logic     rst      = 1'b1;
  logic     req_val  = 1'b0;
  logic     req_rdy;
  mem_msg_t req_msg  = '0;
  logic     resp_val;
  logic     resp_rdy = 1'b1;
  mem_msg_t resp_msg;
`ifdef PIPELINED_MEM_SERVER_LOAD_PORT_EN
  logic        load_en   = 1'b0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_data = '0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  pipelined_mem_server #(
    .p_num_words  (256),
    .p_latency    (2),
    .p_resp_depth (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef PIPELINED_MEM_SERVER_LOAD_PORT_EN
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
`endif
    .req_val   (req_val),
    .req_rdy   (req_rdy),
    .req_msg   (req_msg),
    .resp_val  (resp_val),
    .resp_rdy  (resp_rdy),
    .resp_msg  (resp_msg)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk_msg(input string tag, input mem_msg_t obs, input mem_msg_t exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_resp(input string tag, input mem_op_t o, input logic [7:0] q,
                          input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    mem_msg_t e;
    e = '{op: o, opaque: q, addr: a, strb: s, data: d};
    chk_bit({tag, ".val"}, resp_val, 1'b1);
    chk_msg({tag, ".msg"}, resp_msg, e);
  endtask

  task automatic drive(input mem_op_t o, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, input logic [7:0] q);
    req_val = 1'b1;
    req_msg = '{op: o, opaque: q, addr: a, strb: s, data: d};
  endtask

  task automatic idle();
    req_val = 1'b0;
  endtask

  initial begin
    // Reset state
    step(2);
    chk_bit("rst.req_rdy", req_rdy, 1'b1);
    chk_bit("rst.resp_val", resp_val, 1'b0);
    rst = 1'b0;
    step();

    // Write then read, latency 2, no bypass
    drive(MEM_MSG_WRITE, 32'h200, 4'hF, 32'hDEADBEEF, 8'h01);
    step();
    chk_bit("wr.no_bypass", resp_val, 1'b0);
    drive(MEM_MSG_READ, 32'h200, 4'hF, 32'h0, 8'h02);
    step();
    idle();
    chk_resp("wr.resp", MEM_MSG_WRITE, 8'h01, 32'h200, 4'hF, 32'h0);
    step();
    chk_resp("rd.resp", MEM_MSG_READ, 8'h02, 32'h200, 4'hF, 32'hDEADBEEF);
    step();
    chk_bit("rd.drained", resp_val, 1'b0);

    // Byte strobes
    drive(MEM_MSG_WRITE, 32'h010, 4'hF, 32'hFFFFFFFF, 8'h10);
    step();
    drive(MEM_MSG_WRITE, 32'h010, 4'h5, 32'h00000000, 8'h11);
    step();
    drive(MEM_MSG_READ, 32'h010, 4'hF, 32'h0, 8'h12);
    chk_resp("strb.w0", MEM_MSG_WRITE, 8'h10, 32'h010, 4'hF, 32'h0);
    step();
    idle();
    chk_resp("strb.w1", MEM_MSG_WRITE, 8'h11, 32'h010, 4'h5, 32'h0);
    step();
    chk_resp("strb.rd", MEM_MSG_READ, 8'h12, 32'h010, 4'hF, 32'hFF00FF00);
    step();

    // Address wrap modulo array size
    drive(MEM_MSG_WRITE, 32'h000, 4'hF, 32'h11111111, 8'h20);
    step();
    drive(MEM_MSG_READ, 32'h400, 4'hF, 32'h0, 8'h21);
    step();
    idle();
    step();
    chk_resp("wrap.rd", MEM_MSG_READ, 8'h21, 32'h400, 4'hF, 32'h11111111);
    step();

    // Preload 0x200..0x23C, then stream 16 reads
    for (int i = 0; i < 16; i++) begin
      drive(MEM_MSG_WRITE, 32'h200 + 32'(4 * i), 4'hF, 32'hA0000000 + 32'(i), 8'h30);
      step();
    end
    idle();
    step(3);
    for (int c = 0; c < 18; c++) begin
      if (c >= 2)
        chk_resp($sformatf("stream%0d", c - 2), MEM_MSG_READ, 8'(c - 2),
                 32'h200 + 32'(4 * (c - 2)), 4'hF, 32'hA0000000 + 32'(c - 2));
      if (c < 16) begin
        chk_bit($sformatf("stream.rdy%0d", c), req_rdy, 1'b1);
        drive(MEM_MSG_READ, 32'h200 + 32'(4 * c), 4'hF, 32'h0, 8'(c));
      end else begin
        idle();
      end
      step();
    end
    chk_bit("stream.drained", resp_val, 1'b0);

    // Backpressure: four credits, then req_rdy drops
    resp_rdy = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk_bit($sformatf("bp.rdy%0d", c), req_rdy, 1'b1);
      drive(MEM_MSG_READ, 32'h200 + 32'(4 * c), 4'hF, 32'h0, 8'h40 + 8'(c));
      step();
    end
    chk_bit("bp.rdy_low", req_rdy, 1'b0);
    step(2);
    chk_bit("bp.rdy_held", req_rdy, 1'b0);
    chk_resp("bp.head", MEM_MSG_READ, 8'h40, 32'h200, 4'hF, 32'hA0000000);
    idle();
    resp_rdy = 1'b1;
    chk_bit("bp.rdy_before_xfer", req_rdy, 1'b0);
    step();
    chk_bit("bp.rdy_after_xfer", req_rdy, 1'b1);
    for (int i = 1; i < 4; i++) begin
      chk_resp($sformatf("bp.resp%0d", i), MEM_MSG_READ, 8'h40 + 8'(i),
               32'h200 + 32'(4 * i), 4'hF, 32'hA0000000 + 32'(i));
      step();
    end
    chk_bit("bp.drained", resp_val, 1'b0);

    // Mid-operation reset drops in-flight responses, keeps array contents
    resp_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(MEM_MSG_READ, 32'h000, 4'hF, 32'h0, 8'h50 + 8'(c));
      step();
    end
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_bit("mrst.resp_val", resp_val, 1'b0);
    chk_bit("mrst.req_rdy", req_rdy, 1'b1);
    step(2);
    chk_bit("mrst.pipe_cleared", resp_val, 1'b0);
    resp_rdy = 1'b1;
    drive(MEM_MSG_READ, 32'h000, 4'hF, 32'h0, 8'h77);
    step();
    idle();
    chk_bit("mrst.no_bypass", resp_val, 1'b0);
    step();
    chk_resp("mrst.preserved", MEM_MSG_READ, 8'h77, 32'h000, 4'hF, 32'h11111111);
    step();
    chk_bit("mrst.drained", resp_val, 1'b0);

`ifdef PIPELINED_MEM_SERVER_LOAD_PORT_EN
    // Load beats a same-cycle request write
    load_en   = 1'b1;
    load_addr = 32'h300;
    load_data = 32'hCAFEF00D;
    drive(MEM_MSG_WRITE, 32'h300, 4'hF, 32'h12345678, 8'h60);
    step();
    load_en = 1'b0;
    drive(MEM_MSG_READ, 32'h300, 4'hF, 32'h0, 8'h61);
    step();
    idle();
    step();
    chk_resp("load.wins", MEM_MSG_READ, 8'h61, 32'h300, 4'hF, 32'hCAFEF00D);
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
